systolic_ctrl: RTL and testbench
================================

// Module: systolic_ctrl
// PURPOSE
//  Sequencer for the NxN systolic array. It runs one matrix-multiply pass:
//  clears the PE accumulators, issues skewed per-row operand-valid strobes,
//  waits for the array to drain, then pulses done.
//  Sits between the top-level start source, the operand buffers and the array.
//  All outputs are registered.
// PARAMETERS
//  N      4   array dimension (rows = cols = N), N >= 1
//  K      4   inner dimension (operand stream length per row), K >= 1
//  CNT_W  8   counter width; 2^CNT_W must exceed K+N-1 (elaboration check)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      begin a pass; sampled only in IDLE
//  stall      in   1      freeze sequencing (operand buffer not ready)
//  busy       out  1      high from the cycle after start is accepted until done clears
//  clear_acc  out  1      one-cycle pulse that zeroes the PE accumulators
//  row_valid  out  N      bit i: operand for row i / col i is valid this cycle
//  feed_cnt   out  CNT_W  feed-phase cycle index; row i reads element feed_cnt-i
//  done       out  1      one-cycle pulse: results stable in the array
// BEHAVIOUR
//  Reset (async, rst_n=0) puts the block in IDLE and sets every output to 0
//  (busy, clear_acc, row_valid, feed_cnt, done). Release is synchronous to clk.
//  FSM states:
//   IDLE  : start=1 -> CLEAR.
//   CLEAR : exactly one cycle, clear_acc=1, cannot be stalled -> FEED, c=0.
//   FEED  : c runs 0..K+N-2 (K+N-1 cycles).
//           row_valid[i] = (c >= i) && (c < i+K); feed_cnt = c.
//           At c = K+N-2 -> DRAIN if N > 1, else -> DONE.
//   DRAIN : N-1 cycles, row_valid = 0 -> DONE.
//   DONE  : one cycle, done=1, busy=1 -> IDLE.
//  busy = 1 in CLEAR, FEED, DRAIN and DONE.
//  Latency with no stalls:
//   start sampled at edge 0 -> clear_acc in cycle 1 -> row_valid[0] first
//   high in cycle 2 -> done in cycle K+2N.
//  stall=1 in FEED or DRAIN:
//   - state, c and the drain counter hold
//   - row_valid is forced to 0 for that cycle
//   - feed_cnt holds
//   stall has no effect in IDLE, CLEAR or DONE.
//  start while busy, including the DONE cycle, is ignored and not queued.
//   A start held high continuously re-launches on the first IDLE cycle.
//  Counters never wrap, because CNT_W is checked against K+N-1.
//  feed_cnt returns to 0 on entry to DRAIN.
//  rst_n low mid-pass aborts immediately to IDLE with all outputs 0.
//   No done is issued for the aborted pass.
// TESTING
//  1 N=4,K=4: start pulse at edge 0 -> clear_acc cycle 1; row_valid
//    cycles 2..8 = 0001,0011,0111,1111,1110,1100,1000; done only in cycle 12.
//  2 stall=1 for 2 cycles at feed c=3 -> row_valid=0 on those cycles,
//    pattern resumes at 1111, done moves to cycle 14.
//  3 start re-pulsed in cycles 5 and 12 -> ignored, exactly one done,
//    busy drops in cycle 13.
//  4 rst_n=0 asynchronously in cycle 6 -> all outputs 0 before the next edge;
//    no done; a new start after release runs a clean full pass.
//  5 N=1,K=1: start -> clear_acc cycle 1, row_valid=1 cycle 2,
//    done cycle 3, no DRAIN state.
//  6 start held high for 30 cycles, N=4,K=4 -> back-to-back passes with done
//    in cycles 12 and 25 (IDLE in cycle 13, relaunch accepted there).

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// Handshake bundle between the systolic-array sequencer and its surroundings.
// The master side is the start source and operand buffers. The slave side is
// the sequencer itself.
interface systolic_ctrl_if #(
   parameter int N     = 4,
   parameter int CNT_W = 8
);

   logic             start;
   logic             stall;
   logic             busy;
   logic             clear_acc;
   logic [N-1:0]     row_valid;
   logic [CNT_W-1:0] feed_cnt;
   logic             done;

   modport master (
      output start,
      output stall,
      input  busy,
      input  clear_acc,
      input  row_valid,
      input  feed_cnt,
      input  done
   );

   modport slave (
      input  start,
      input  stall,
      output busy,
      output clear_acc,
      output row_valid,
      output feed_cnt,
      output done
   );

endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for one NxN systolic matrix-multiply pass.
// A pass clears the PE accumulators and then feeds skewed per-row operand
// strobes. It then waits N-1 cycles for the array to drain and pulses done.
// Every output is driven straight from a flop.
//
// next_idx holds the feed index to be presented after the next unstalled
// edge. A stall therefore blanks row_valid without consuming an index. When
// the stall releases, the pattern resumes at the element that was held back.
module systolic_ctrl #(
   parameter int N     = 4,
   parameter int K     = 4,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   systolic_ctrl_if.slave    bus
);

   // Refuse to build a configuration whose counters could wrap.
   if (N < 1) begin : g_bad_n
      $error("systolic_ctrl: N must be at least 1");
   end
   if (K < 1) begin : g_bad_k
      $error("systolic_ctrl: K must be at least 1");
   end
   if ((2 ** CNT_W) <= (K + N - 1)) begin : g_bad_cnt_w
      $error("systolic_ctrl: CNT_W too narrow for K+N-1");
   end

   // One past the last feed index. Reaching it ends the feed phase.
   localparam logic [CNT_W-1:0] FEED_END   = CNT_W'(K + N - 1);
   // The drain phase lasts this many cycles.
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((N > 1) ? (N - 1) : 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] next_idx;
   logic [CNT_W-1:0] drain_cnt;

   logic             busy_q;
   logic             clear_acc_q;
   logic [N-1:0]     row_valid_q;
   logic [CNT_W-1:0] feed_cnt_q;
   logic             done_q;

   // Row i is live while its K-element stream, delayed by i cycles, is
   // passing through index c.
   function automatic logic [N-1:0] feed_pattern(input logic [CNT_W-1:0] c);
      logic [N-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++) begin
         p[i] = (int'(c) >= i) && (int'(c) < (i + K));
      end
      return p;
   endfunction

   // Pass sequencer. It advances state and counters, and it registers every
   // output for the cycle that follows the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         next_idx    <= '0;
         drain_cnt   <= '0;
         busy_q      <= 1'b0;
         clear_acc_q <= 1'b0;
         row_valid_q <= '0;
         feed_cnt_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         clear_acc_q <= 1'b0;
         done_q      <= 1'b0;
         case (state)
            IDLE: begin
               row_valid_q <= '0;
               feed_cnt_q  <= '0;
               busy_q      <= 1'b0;
               if (bus.start) begin
                  state       <= CLEAR;
                  clear_acc_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            CLEAR: begin
               state       <= FEED;
               row_valid_q <= feed_pattern('0);
               feed_cnt_q  <= '0;
               next_idx    <= CNT_W'(1);
            end
            FEED: begin
               if (bus.stall) begin
                  row_valid_q <= '0;
               end else if (next_idx == FEED_END) begin
                  row_valid_q <= '0;
                  feed_cnt_q  <= '0;
                  next_idx    <= '0;
                  if (N > 1) begin
                     state     <= DRAIN;
                     drain_cnt <= CNT_W'(1);
                  end else begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end else begin
                  row_valid_q <= feed_pattern(next_idx);
                  feed_cnt_q  <= next_idx;
                  next_idx    <= next_idx + CNT_W'(1);
               end
            end
            DRAIN: begin
               row_valid_q <= '0;
               if (!bus.stall) begin
                  if (drain_cnt == DRAIN_LAST) begin
                     state     <= DONE;
                     drain_cnt <= '0;
                     done_q    <= 1'b1;
                  end else begin
                     drain_cnt <= drain_cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               busy_q      <= 1'b0;
               row_valid_q <= '0;
               feed_cnt_q  <= '0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.clear_acc = clear_acc_q;
   assign bus.row_valid = row_valid_q;
   assign bus.feed_cnt  = feed_cnt_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl.
// It drives a 4x4/K=4 instance and a 1x1/K=1 instance.
// The expected waveforms are written out by hand for each pass.
module tb_systolic_ctrl;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;
   int   cyc;

   systolic_ctrl_if #(.N(4), .CNT_W(8)) bus4 ();
   systolic_ctrl_if #(.N(1), .CNT_W(8)) bus1 ();

   systolic_ctrl #(.N(4), .K(4), .CNT_W(8)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   systolic_ctrl #(.N(1), .K(1), .CNT_W(8)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge; cyc then names the cycle now visible.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, observed, expected);
      end
   endtask

   initial begin
      logic [3:0] rv1 [0:15];
      logic [7:0] fc1 [0:15];
      logic [3:0] rv2 [0:15];
      logic [7:0] fc2 [0:15];
      int done_count;
      int done_at [0:3];

      tests_run    = 0;
      tests_failed = 0;
      cyc          = 0;
      rst_n        = 1'b0;
      bus4.start   = 1'b0;
      bus4.stall   = 1'b0;
      bus1.start   = 1'b0;
      bus1.stall   = 1'b0;

      // Expected waveforms for an unstalled pass and for a pass with two stall cycles.
      rv1 = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC,
              4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      fc1 = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
              8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      rv2 = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'h0, 4'h0, 4'hF,
              4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      fc2 = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3,
              8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_busy",      32'(bus4.busy),      32'd0);
      check_output("rst_clear_acc", 32'(bus4.clear_acc), 32'd0);
      check_output("rst_row_valid", 32'(bus4.row_valid), 32'd0);
      check_output("rst_feed_cnt",  32'(bus4.feed_cnt),  32'd0);
      check_output("rst_done",      32'(bus4.done),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Scenario 1: a plain pass.
      cyc = 0;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      check_output("t1_clear_acc", 32'(bus4.clear_acc), 32'd1);
      check_output("t1_busy_c1",   32'(bus4.busy),      32'd1);
      check_output("t1_rv_c1",     32'(bus4.row_valid), 32'd0);
      while (cyc < 13) begin
         tick();
         check_output("t1_row_valid", 32'(bus4.row_valid), 32'(rv1[cyc]));
         check_output("t1_feed_cnt",  32'(bus4.feed_cnt),  32'(fc1[cyc]));
         check_output("t1_done",      32'(bus4.done),      32'(cyc == 12));
         check_output("t1_busy",      32'(bus4.busy),      32'(cyc <= 12));
         check_output("t1_clr_low",   32'(bus4.clear_acc), 32'd0);
      end

      // Scenario 2: stall is high in cycles 4 and 5, so two blank cycles follow.
      cyc = 0;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      while (cyc < 15) begin
         tick();
         if (cyc == 4) bus4.stall = 1'b1;
         if (cyc == 6) bus4.stall = 1'b0;
         check_output("t2_row_valid", 32'(bus4.row_valid), 32'(rv2[cyc]));
         check_output("t2_feed_cnt",  32'(bus4.feed_cnt),  32'(fc2[cyc]));
         check_output("t2_done",      32'(bus4.done),      32'(cyc == 14));
         check_output("t2_busy",      32'(bus4.busy),      32'(cyc <= 14));
      end

      // Scenario 3: start is re-pulsed in cycles 5 and 12 while busy.
      cyc = 0;
      done_count = 0;
      done_at[0] = -1;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      while (cyc < 20) begin
         tick();
         bus4.start = (cyc == 5) || (cyc == 12);
         if (bus4.done) begin
            if (done_count < 4) done_at[done_count] = cyc;
            done_count++;
         end
         if (cyc == 12) check_output("t3_busy_c12", 32'(bus4.busy), 32'd1);
         if (cyc == 13) check_output("t3_busy_c13", 32'(bus4.busy), 32'd0);
      end
      bus4.start = 1'b0;
      check_output("t3_done_count", 32'(done_count), 32'd1);
      check_output("t3_done_cycle", 32'(done_at[0]), 32'd12);
      check_output("t3_idle_busy",  32'(bus4.busy),  32'd0);

      // Scenario 4: an asynchronous reset mid-pass aborts without done.
      cyc = 0;
      done_count = 0;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      while (cyc < 6) tick();
      check_output("t4_rv_before", 32'(bus4.row_valid), 32'hE);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("t4_busy",      32'(bus4.busy),      32'd0);
      check_output("t4_row_valid", 32'(bus4.row_valid), 32'd0);
      check_output("t4_feed_cnt",  32'(bus4.feed_cnt),  32'd0);
      check_output("t4_clear_acc", 32'(bus4.clear_acc), 32'd0);
      check_output("t4_done",      32'(bus4.done),      32'd0);
      repeat (3) begin
         tick();
         if (bus4.done) done_count++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         tick();
         if (bus4.done) done_count++;
      end
      check_output("t4_no_done_abort", 32'(done_count), 32'd0);
      cyc = 0;
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      check_output("t4_re_clear", 32'(bus4.clear_acc), 32'd1);
      done_at[0] = -1;
      while (cyc < 14) begin
         tick();
         if (bus4.done) begin
            if (done_count < 4) done_at[done_count] = cyc;
            done_count++;
         end
         if (cyc == 5) check_output("t4_rv_c5", 32'(bus4.row_valid), 32'hF);
      end
      check_output("t4_re_done_count", 32'(done_count), 32'd1);
      check_output("t4_re_done_cycle", 32'(done_at[0]), 32'd12);

      // Scenario 5: the 1x1 array goes from feed straight to done.
      cyc = 0;
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      check_output("t5_clear_c1", 32'(bus1.clear_acc), 32'd1);
      check_output("t5_rv_c1",    32'(bus1.row_valid), 32'd0);
      tick();
      check_output("t5_rv_c2",    32'(bus1.row_valid), 32'd1);
      check_output("t5_done_c2",  32'(bus1.done),      32'd0);
      check_output("t5_clear_c2", 32'(bus1.clear_acc), 32'd0);
      tick();
      check_output("t5_done_c3",  32'(bus1.done),      32'd1);
      check_output("t5_rv_c3",    32'(bus1.row_valid), 32'd0);
      check_output("t5_busy_c3",  32'(bus1.busy),      32'd1);
      tick();
      check_output("t5_busy_c4",  32'(bus1.busy),      32'd0);
      check_output("t5_done_c4",  32'(bus1.done),      32'd0);

      // Scenario 6: start held high for 30 cycles gives back-to-back passes.
      cyc = 0;
      done_count = 0;
      for (int j = 0; j < 4; j++) done_at[j] = -1;
      bus4.start = 1'b1;
      while (cyc < 45) begin
         tick();
         if (cyc == 30) bus4.start = 1'b0;
         if (bus4.done) begin
            if (done_count < 4) done_at[done_count] = cyc;
            done_count++;
         end
         if (cyc == 13) check_output("t6_idle_c13", 32'(bus4.busy), 32'd0);
      end
      check_output("t6_done_count", 32'(done_count), 32'd3);
      check_output("t6_done_first", 32'(done_at[0]), 32'd12);
      check_output("t6_done_second", 32'(done_at[1]), 32'd25);
      check_output("t6_done_third", 32'(done_at[2]), 32'd38);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
